// File: rtl/decode_unpack_if.sv
// Handshake bundle for decode_unpack: start/width control, packed-word input
// stream and the coefficient output stream.
interface decode_unpack_if;
  logic        i_start;
  logic [3:0]  i_l;
  logic [63:0] i_words;
  logic        i_words_valid;
  logic        o_words_ready;
  logic [11:0] o_coeff;
  logic        o_coeff_valid;
  logic        i_coeff_ready;
  logic [7:0]  o_idx;
  logic        o_busy;
  logic        o_done;

  modport slave (
    input  i_start, i_l, i_words, i_words_valid, i_coeff_ready,
    output o_words_ready, o_coeff, o_coeff_valid, o_idx, o_busy, o_done
  );

  modport master (
    output i_start, i_l, i_words, i_words_valid, i_coeff_ready,
    input  o_words_ready, o_coeff, o_coeff_valid, o_idx, o_busy, o_done
  );
endinterface

// File: rtl/decode_unpack.sv
// Bit-splitting half of ByteDecode_l: unpacks 4*l little-endian 64-bit words
// into 256 l-bit coefficients, reducing mod Q when l = 12.
module decode_unpack #(
  parameter int Q      = 3329,
  parameter int NCOEFF = 256
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  decode_unpack_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q;
  logic [3:0]   l_q;
  logic [127:0] buf_q, buf_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [5:0]   words_q;
  logic [8:0]   loaded_q;
  logic [11:0]  coeff_q;
  logic         valid_q;
  logic [7:0]   idx_q;

  logic         l_legal, run, word_acc, coeff_hs, load;
  logic [11:0]  raw, reduced;
  logic [127:0] shifted;
  logic [7:0]   cnt_after;

  assign l_legal  = (bus.i_l == 4'd1)  || (bus.i_l == 4'd4)  || (bus.i_l == 4'd5) ||
                    (bus.i_l == 4'd10) || (bus.i_l == 4'd11) || (bus.i_l == 4'd12);
  assign run      = (state_q == RUN);
  assign bus.o_words_ready = run && (cnt_q <= 8'd64) && (words_q < {l_q, 2'b00});
  assign word_acc = bus.i_words_valid && bus.o_words_ready;
  assign coeff_hs = valid_q && bus.i_coeff_ready;
  assign load     = run && (cnt_q >= {4'd0, l_q}) && (loaded_q < 9'(NCOEFF)) &&
                    (!valid_q || bus.i_coeff_ready);

  // NOTE: every signal gets a value on every path through always_comb, so
  // no latch is inferred even though most are only meaningful when loading.
  always_comb begin
    raw       = buf_q[11:0] & ((12'd1 << l_q) - 12'd1);
    reduced   = ((l_q == 4'd12) && (raw >= 12'(Q))) ? raw - 12'(Q) : raw;
    shifted   = load ? (buf_q >> l_q) : buf_q;
    cnt_after = load ? (cnt_q - {4'd0, l_q}) : cnt_q;
    // Bits at and above cnt are always zero, so appending is a plain OR.
    buf_d     = word_acc ? (shifted | ({64'd0, bus.i_words} << cnt_after)) : shifted;
    cnt_d     = word_acc ? (cnt_after + 8'd64) : cnt_after;
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values; the bit buffer is ordinary flops and is reset so an
  // aborted polynomial leaves no stale bits behind.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      l_q      <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
      loaded_q <= '0;
      coeff_q  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start && l_legal) begin
            l_q      <= bus.i_l;
            buf_q    <= '0;
            cnt_q    <= '0;
            words_q  <= '0;
            loaded_q <= '0;
            coeff_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          buf_q <= buf_d;
          cnt_q <= cnt_d;
          if (word_acc) words_q <= words_q + 6'd1;
          if (load) begin
            coeff_q  <= reduced;
            loaded_q <= loaded_q + 9'd1;
            valid_q  <= 1'b1;
          end else if (coeff_hs) begin
            valid_q  <= 1'b0;
          end
          if (coeff_hs) begin
            idx_q <= idx_q + 8'd1;
            if (idx_q == 8'(NCOEFF - 1)) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_coeff       = coeff_q;
  assign bus.o_coeff_valid = valid_q;
  assign bus.o_idx         = idx_q;
  assign bus.o_busy        = run;
  assign bus.o_done        = (state_q == DONE);

endmodule

// File: tb/tb_decode_unpack.sv
// Self-checking bench for decode_unpack: coefficients are compared against a
// bit-stream model that slices the packed words directly.
module tb_decode_unpack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  decode_unpack_if bus();

  decode_unpack dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] stim[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Coefficient n is stream bits n*l .. n*l+l-1, LSB first, reduced mod 3329 for l=12.
  function automatic logic [11:0] exp_coeff(input int l, input int n);
    int          v = 0;
    int          p;
    logic [63:0] w;
    for (int i = 0; i < l; i++) begin
      p = n * l + i;
      w = stim[p / 64];
      v = v | (int'(w[p % 64]) << i);
    end
    if (l == 12 && v >= 3329) v = v - 3329;
    return 12'(v);
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back({$urandom, $urandom});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.o_words_ready), 64'd0);
    check({tag, "_coeff"}, 64'(bus.o_coeff), 64'd0);
    check({tag, "_valid"}, 64'(bus.o_coeff_valid), 64'd0);
    check({tag, "_idx"},   64'(bus.o_idx), 64'd0);
    check({tag, "_busy"},  64'(bus.o_busy), 64'd0);
    check({tag, "_done"},  64'(bus.o_done), 64'd0);
  endtask

  task automatic start_poly(input logic [3:0] l);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_l     = l;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // vmode: 0 = words always valid, 1 = random valid.
  // rmode: 0 = always ready, 1 = toggling 1,0,1,0, 2 = random ready.
  task automatic run_poly(input int l, input int vmode, input int rmode, input int abort_after);
    int          wi = 0, ci = 0, cyc = 0;
    bit          stalled = 1'b0, extra = 1'b0, rtog = 1'b1;
    logic [11:0] hc;
    logic [7:0]  hi;
    while (ci < 256 && cyc < 6000) begin
      bus.i_words_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.i_words       = (wi < stim.size()) ? stim[wi] : {$urandom, $urandom};
      case (rmode)
        0:       bus.i_coeff_ready = 1'b1;
        1:       begin bus.i_coeff_ready = rtog; rtog = ~rtog; end
        default: bus.i_coeff_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        check("stall_coeff", 64'(bus.o_coeff), 64'(hc));
        check("stall_idx",   64'(bus.o_idx),   64'(hi));
        stalled = 1'b0;
      end
      if (wi >= 4 * l && bus.o_words_ready) extra = 1'b1;
      if (bus.i_words_valid && bus.o_words_ready) wi++;
      if (bus.o_coeff_valid) begin
        if (bus.i_coeff_ready) begin
          check($sformatf("coeff_l%0d_n%0d", l, ci), 64'(bus.o_coeff), 64'(exp_coeff(l, ci)));
          check($sformatf("idx_l%0d_n%0d", l, ci),   64'(bus.o_idx),   64'(ci));
          ci++;
        end else begin
          stalled = 1'b1;
          hc      = bus.o_coeff;
          hi      = bus.o_idx;
        end
      end
      if (abort_after > 0 && ci == abort_after) break;
      @(negedge clk);
      cyc++;
    end
    if (abort_after > 0 && ci == abort_after) return;
    bus.i_words_valid = 1'b0;
    check($sformatf("coeff_count_l%0d", l), 64'(ci), 64'd256);
    check($sformatf("words_taken_l%0d", l), 64'(wi), 64'(4 * l));
    check($sformatf("no_extra_ready_l%0d", l), 64'(extra), 64'd0);
    #1;
    check($sformatf("done_pulse_l%0d", l), 64'(bus.o_done), 64'd1);
    check($sformatf("busy_low_l%0d", l),   64'(bus.o_busy), 64'd0);
    @(negedge clk);
    #1;
    check($sformatf("done_single_l%0d", l), 64'(bus.o_done), 64'd0);
  endtask

  initial begin
    bus.i_start       = 1'b0;
    bus.i_l           = 4'd0;
    bus.i_words       = 64'd0;
    bus.i_words_valid = 1'b0;
    bus.i_coeff_ready = 1'b0;
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // l=4: nibbles of the first word come out LSB-first.
    stim.delete();
    stim.push_back(64'h0123456789ABCDEF);
    for (int i = 1; i < 16; i++) stim.push_back(64'd0);
    start_poly(4'd4);
    run_poly(4, 0, 0, 0);

    // l=12 all ones: every coefficient 4095 reduces to 766.
    stim.delete();
    for (int i = 0; i < 48; i++) stim.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    start_poly(4'd12);
    run_poly(12, 0, 0, 0);

    // l=12 reduction boundary: 3328 passes, 3329 becomes 0; rest random.
    fill_random(48);
    stim[0] = 64'h0000_0000_00D0_1D00;
    start_poly(4'd12);
    run_poly(12, 1, 2, 0);

    // l=11 coefficient straddling the first word boundary.
    fill_random(44);
    stim[0] = 64'h0000_0000_0000_07FF;
    stim[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    start_poly(4'd11);
    run_poly(11, 0, 0, 0);

    // l=1 with downstream ready toggling: output held stable while stalled.
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(64'h5555_5555_5555_5555);
    start_poly(4'd1);
    run_poly(1, 0, 1, 0);

    // Illegal width: start is ignored.
    start_poly(4'd3);
    bus.i_words_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("illegal_ready", 64'(bus.o_words_ready), 64'd0);
    check("illegal_valid", 64'(bus.o_coeff_valid), 64'd0);
    check("illegal_busy",  64'(bus.o_busy), 64'd0);
    bus.i_words_valid = 1'b0;

    fill_random(20);
    start_poly(4'd5);
    run_poly(5, 1, 2, 0);

    // l=10 aborted by reset after 100 coefficients, then a clean restart.
    fill_random(40);
    start_poly(4'd10);
    run_poly(10, 0, 0, 100);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_words_valid = 1'b0;
    fill_random(40);
    start_poly(4'd10);
    run_poly(10, 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
